// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier: one multiplier bit per clock, start/busy/done
// handshake, signed/unsigned mode, early exit once the remaining multiplier bits are zero.
module seq_mult_hs #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   y,
  output logic [CW-1:0]        cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   ra, ra_nxt;
  logic [WIDTH-1:0]     rb, rb_nxt;
  logic [2*WIDTH-1:0]   ry, ry_nxt;
  logic                 neg, neg_nxt;
  logic                 done_nxt;
  logic [2*WIDTH-1:0]   y_nxt;
  logic [CW-1:0]        cnt_nxt;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is
  // exactly its magnitude when read as unsigned.
  always_comb begin
    mag_a = (sgn && a[WIDTH-1]) ? (-a) : a;
    mag_b = (sgn && b[WIDTH-1]) ? (-b) : b;
  end

  always_comb begin
    state_nxt = state;
    ra_nxt    = ra;
    rb_nxt    = rb;
    ry_nxt    = ry;
    neg_nxt   = neg;
    done_nxt  = 1'b0;
    y_nxt     = y;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          ra_nxt    = {{WIDTH{1'b0}}, mag_a};
          rb_nxt    = mag_b;
          ry_nxt    = '0;
          cnt_nxt   = '0;
          neg_nxt   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (rb != '0) begin
          if (rb[0]) ry_nxt = ry + ra;
          ra_nxt  = ra << 1;
          rb_nxt  = rb >> 1;
          cnt_nxt = cnt + CW'(1);
        end else begin
          y_nxt     = neg ? (-ry) : ry;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      ry    <= '0;
      neg   <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ra    <= ra_nxt;
      rb    <= rb_nxt;
      ry    <= ry_nxt;
      neg   <= neg_nxt;
      done  <= done_nxt;
      y     <= y_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb busy = (state == RUN);

endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench for seq_mult_hs: table vectors plus random operands through a
// scoreboard queue, and hand-written handshake and mid-operation reset sequences.
module tb_seq_mult_hs;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           sgn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] y;
  logic [CW-1:0]  cnt;

  seq_mult_hs #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] y;
    logic [CW-1:0]  cnt;
  } exp_t;

  typedef struct {
    logic           s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] y;
    logic [CW-1:0]  cnt;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference product from sign/zero-extended operands multiplied at full width.
  function automatic exp_t model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t                 e;
    logic signed [2*W-1:0] xa, xb;
    logic [W-1:0]          mb;
    xa = s ? {{W{av[W-1]}}, av} : {{W{1'b0}}, av};
    xb = s ? {{W{bv[W-1]}}, bv} : {{W{1'b0}}, bv};
    e.y = xa * xb;
    mb = (s && bv[W-1]) ? (-bv) : bv;
    e.cnt = '0;
    for (int i = 0; i < W; i++) if (mb[i]) e.cnt = CW'(i + 1);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 y=%0h required no completion", y);
      end else begin
        e = sb.pop_front();
        chk("done_y", 32'(y), 32'(e.y));
        chk("done_cnt", 32'(cnt), 32'(e.cnt));
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  // Called just after a falling edge; returns on the falling edge where done is seen.
  task automatic do_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input exp_t e, input string name);
    int cyc;
    sgn = s; a = av; b = bv; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3 * W) begin
      chk({name, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(e.cnt) + 32'd1);
    if (!done) sb.delete();
  endtask

  vec_t tbl[11];
  exp_t e;
  int   cyc;

  initial begin
    tbl[0]  = '{1'b0, 8'd200, 8'd150, 16'h7530, 4'd8};
    tbl[1]  = '{1'b0, 8'd37,  8'd0,   16'h0000, 4'd0};
    tbl[2]  = '{1'b1, 8'hFD,  8'h05,  16'hFFF1, 4'd3};
    tbl[3]  = '{1'b0, 8'hFF,  8'h02,  16'h01FE, 4'd2};
    tbl[4]  = '{1'b1, 8'hFF,  8'h02,  16'hFFFE, 4'd2};
    tbl[5]  = '{1'b1, 8'h80,  8'h80,  16'h4000, 4'd8};
    tbl[6]  = '{1'b1, 8'h80,  8'h01,  16'hFF80, 4'd1};
    tbl[7]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01, 4'd8};
    tbl[8]  = '{1'b1, 8'h7F,  8'h81,  16'hC0FF, 4'd7};
    tbl[9]  = '{1'b1, 8'h00,  8'h80,  16'h0000, 4'd8};
    tbl[10] = '{1'b0, 8'h01,  8'h80,  16'h0080, 4'd8};

    rst = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_y",    32'(y),    32'd0);
    chk("reset_cnt",  32'(cnt),  32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      e.y   = tbl[i].y;
      e.cnt = tbl[i].cnt;
      do_op(tbl[i].s, tbl[i].a, tbl[i].b, e, $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    for (int i = 0; i < 20; i++) begin
      logic           rs;
      logic [W-1:0]   ra, rb;
      rs = 1'($urandom_range(1, 0));
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(rs, ra, rb, model(rs, ra, rb), $sformatf("rnd%0d", i));
    end
    @(negedge clk);

    // start while busy is ignored; start in the done cycle is accepted
    sgn = 1'b0; a = 8'd3; b = 8'd255; start = 1'b1;
    e.y = 16'd765; e.cnt = 4'd8; sb.push_back(e);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 8'd9; b = 8'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3 * W) begin @(negedge clk); cyc++; end
    chk("hs_first_done", 32'(done), 32'd1);
    chk("hs_first_y", 32'(y), 32'd765);
    a = 8'd6; b = 8'd7; start = 1'b1;
    e.y = 16'd42; e.cnt = 4'd3; sb.push_back(e);
    @(negedge clk); start = 1'b0;
    chk("hs_accept_busy", 32'(busy), 32'd1);
    chk("hs_accept_done", 32'(done), 32'd0);
    cyc = 0;
    while (!done && cyc < 3 * W) begin
      chk("hs_y_hold", 32'(y), 32'd765);
      @(negedge clk);
      cyc++;
    end
    chk("hs_second_latency", 32'(cyc), 32'd4);
    if (!done) sb.delete();
    @(negedge clk);

    // reset in the middle of an operation
    sgn = 1'b0; a = 8'd200; b = 8'd150; start = 1'b1;
    e.y = 16'h7530; e.cnt = 4'd8; sb.push_back(e);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_y",    32'(y),    32'd0);
    chk("midrst_cnt",  32'(cnt),  32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("postrst_idle_busy", 32'(busy), 32'd0);
    chk("postrst_y", 32'(y), 32'd0);
    e.y = 16'd144; e.cnt = 4'd4;
    do_op(1'b0, 8'd12, 8'd12, e, "postrst");
    @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
Parametrised sequential shift-add multiplier with a start/busy/done handshake, a signed/unsigned mode select and early termination. It processes one multiplier bit per clock. It finishes as soon as the remaining multiplier bits are all zero. It replaces the fixed 4-bit load-driven multiplier in the arithmetic datapath experiments and is driven by a simple controller or a testbench.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits
CW, $clog2(WIDTH+1) (localparam), width of step counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
start  input  1  request; sampled only when busy=0
sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand, sampled with start
b  input  WIDTH  multiplier, sampled with start
busy  output  1  high while a multiplication is in progress
done  output  1  one-cycle pulse; y valid from this cycle onward
y  output  2*WIDTH  result register; holds last result until next completion
cnt  output  CW  add/shift steps executed in current/last operation

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, y=0, cnt=0, internal ra/rb/ry/neg=0. Reset mid-operation aborts it; no done is issued.
- Internal registers: ra (2*WIDTH, shifted multiplicand), rb (WIDTH, shifted multiplier), ry (2*WIDTH accumulator), neg (1).
- IDLE, busy=0: done clears to 0 at each edge unless set by completion. start=1 at edge E0 does the following:
  - ra <= zero-extended |a|; rb <= |b|; ry <= 0; cnt <= 0.
  - neg <= sgn & (a[MSB]^b[MSB]).
  - State goes to RUN; busy <= 1.
- Operand magnitude: when sgn=1 and MSB=1, magnitude is the two's-complement negation taken as WIDTH-bit unsigned. The most negative value maps to 2^(WIDTH-1) correctly. When sgn=0, the operand is used as-is.
- RUN, busy=1, one action per edge:
  - rb != 0: if rb[0]=1 then ry <= ry + ra (mod 2^(2W)). Also ra <= ra<<1, rb <= rb>>1, cnt <= cnt+1.
  - rb == 0: y <= neg ? (-ry mod 2^(2W)) : ry; done <= 1; busy <= 0; state goes to IDLE. cnt is held.
- Latency: let k = bit length of |b| (0 when b=0). Steps run at E1..Ek. Completion happens at E(k+1), so done is high in the cycle after E(k+1). Worst case is WIDTH+1 cycles; b=0 takes 1 cycle.
- start while busy=1: ignored; no effect on operands, state or outputs.
- start=1 in the done cycle: accepted, since busy=0. done drops at that edge and the new operation begins. y keeps the just-written result until the new completion.
- y and cnt never change during RUN except cnt incrementing. y changes only at completion or reset.
- Signed overflow is impossible: the 2*WIDTH-bit product covers every signed×signed and unsigned×unsigned case.
- ra never overflows: at most WIDTH shifts of a WIDTH-bit value into 2*WIDTH bits.

Test Plan:
1. Reset, sgn=0, a=200, b=150, start 1 cycle -> busy 1 for 9 cycles; done pulse at E9; y=16'h7530; cnt=8.
2. sgn=0, a=37, b=0 -> done at E1; y=0; cnt=0; busy high exactly 1 cycle.
3. sgn=1, a=8'hFD (-3), b=5 -> done at E4; y=16'hFFF1 (-15); cnt=3. Then sgn=0, a=8'hFF, b=2 -> y=16'h01FE (510). Then sgn=1, same operands -> y=16'hFFFE (-2).
4. sgn=1, a=8'h80, b=8'h80 -> y=16'h4000; cnt=8; done at E9. Then a=8'h80, b=8'h01 -> y=16'hFF80.
5. Handshake stress:
   - Start a=3, b=255. Pulse start with a=9, b=9 at E3: ignored, and the result is 765 (16'h02FD).
   - Assert start with a=6, b=7 during the done cycle: accepted, and the next done gives y=42.
   - y holds 765 throughout the second run.
6. Start a=200, b=150. Drop rst for 1 cycle at E4: busy, done, y and cnt go to 0 immediately. No done pulse afterwards. A fresh start of 12×12 after reset release gives y=144.
